// File: rtl/pio_ctrl_pkg.sv
// Shared definitions for the I/O-page cycle controller: FSM state encoding,
// region indices and the wait-state table reset values.
package pio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ACK   = 2'd2,
        ST_BERR  = 2'd3
    } pio_state_e;

    localparam int NUM_REGIONS = 8;

    // Several peripherals share a region because they share a timing class.
    localparam logic [2:0] RGN_POST    = 3'd0;
    localparam logic [2:0] RGN_OUTP    = 3'd0;
    localparam logic [2:0] RGN_PIO2    = 3'd0;
    localparam logic [2:0] RGN_SPI     = 3'd0;
    localparam logic [2:0] RGN_UART    = 3'd1;
    localparam logic [2:0] RGN_PIT     = 3'd1;
    localparam logic [2:0] RGN_PCF     = 3'd1;
    localparam logic [2:0] RGN_OVERLAY = 3'd1;
    localparam logic [2:0] RGN_USB     = 3'd2;
    localparam logic [2:0] RGN_INTC    = 3'd3;

    localparam logic [3:0] WS_RST_R0    = 4'd1;
    localparam logic [3:0] WS_RST_R1    = 4'd3;
    localparam logic [3:0] WS_RST_R2    = 4'd4;
    localparam logic [3:0] WS_RST_R3    = 4'd0;
    localparam logic [3:0] WS_RST_UPPER = 4'd15;

    function automatic logic [3:0] ws_reset_val(input logic [2:0] idx);
        logic [3:0] val;
        case (idx)
            3'd0:    val = WS_RST_R0;
            3'd1:    val = WS_RST_R1;
            3'd2:    val = WS_RST_R2;
            3'd3:    val = WS_RST_R3;
            default: val = WS_RST_UPPER;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pio_sync2.sv
// Two-flop synchronizer; asynchronous reset drives both flops to RST_VAL,
// which callers set to the input's inactive level.
module pio_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pio_cycle_controller.sv
// I/O-page bus-cycle sequencer: per-region wait states, optional ext_ready
// handshake, DTACK/BERR generation. Define PIO_BERR_EN to build the timeout.
module pio_cycle_controller
    import pio_ctrl_pkg::*;
#(
    parameter int         WS_WIDTH       = 4,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] EXT_MASK       = 8'b0000_0100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                as_n,
    input  logic                cs,
    input  logic                rw_n,
    input  logic [2:0]          adm,
    input  logic                ext_ready,
    input  logic                ws_we,
    input  logic [2:0]          ws_sel,
    input  logic [WS_WIDTH-1:0] ws_data,
    output logic                dtack_n,
    output logic                berr_n,
    output logic                cycle_active,
    output logic [2:0]          region,
    output logic                cycle_rw_n
);

    generate
        if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("pio_cycle_controller: TIMEOUT_CYCLES out of range 16..65535");
        end
    endgenerate

    logic as_n_sync;
    logic as_sync;

    pio_sync2 #(.RST_VAL(1'b1)) u_as_sync (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (as_n),
        .q_o   (as_n_sync)
    );

    assign as_sync = ~as_n_sync;

    logic [WS_WIDTH-1:0] ws_q [NUM_REGIONS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                ws_q[i] <= WS_WIDTH'(ws_reset_val(3'(i)));
            end
        end else if (ws_we) begin
            ws_q[ws_sel] <= ws_data;
        end
    end

    pio_state_e          state_q, state_d;
    logic [WS_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]          region_q, region_d;
    logic                rw_q, rw_d;

`ifdef PIO_BERR_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            region_q <= 3'd0;
            rw_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            region_q <= region_d;
            rw_q     <= rw_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        region_d = region_q;
        rw_d     = rw_q;
`ifdef PIO_BERR_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (as_sync && cs) begin
                    region_d = adm;
                    rw_d     = rw_n;
                    cnt_d    = ws_q[adm];
`ifdef PIO_BERR_EN
                    tmo_d    = '0;
`endif
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                // Only the host strobe ends a cycle; cs dropping is ignored.
                if (!as_sync) begin
                    state_d = ST_IDLE;
                end
`ifdef PIO_BERR_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_BERR;
                end
`endif
                else if (cnt_q == '0 && (!EXT_MASK[region_q] || ext_ready)) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
`ifdef PIO_BERR_EN
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            ST_ACK, ST_BERR: begin
                if (!as_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register directly, so they reset asynchronously.
    assign dtack_n      = (state_q != ST_ACK);
`ifdef PIO_BERR_EN
    assign berr_n       = (state_q != ST_BERR);
`else
    assign berr_n       = 1'b1;
`endif
    assign cycle_active = (state_q != ST_IDLE);
    assign region       = region_q;
    assign cycle_rw_n   = rw_q;

endmodule
